// File: rtl/num2ascii_dec_if.sv
// Handshake bundle between a counter source and the ASCII decimal serialiser.
// The master side starts conversions and consumes characters; the slave side is the converter.
interface num2ascii_dec_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              start_update;
    logic [DATA_W-1:0] value;
    logic              busy;
    logic [7:0]        char;
    logic              valid_o;
    logic              ready_i;
    logic              last_o;

    modport master (
        output start_update, value, ready_i,
        input  busy, char, valid_o, last_o
    );

    modport slave (
        input  start_update, value, ready_i,
        output busy, char, valid_o, last_o
    );
endinterface

// File: rtl/num2ascii_dec.sv
// Binary to decimal ASCII serialiser: double-dabble conversion, then one character per
// handshake with optional sign, leading-zero suppression and terminator.
module num2ascii_dec #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DIGITS         = 10,
    parameter bit          SIGNED         = 1'b0,
    parameter bit          SUPPRESS_ZEROS = 1'b1,
    parameter bit          TERM_EN        = 1'b0,
    parameter logic [7:0]  TERM_CHAR      = 8'h0A
) (
    input  logic           CLK,
    input  logic           RST,
    num2ascii_dec_if.slave bus
);
    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DATA_W + 1);
    localparam int unsigned PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_PREP, S_EMIT} state_e;
    typedef enum logic [1:0] {P_SIGN, P_DIGIT, P_TERM} pos_e;

    state_e            state_q, state_d;
    pos_e              pos_q, pos_d;
    logic [DATA_W-1:0] mag_q, mag_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [7:0]        char_q, char_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              busy_q, busy_d;

    logic [BW-1:0]     bcd_adj;
    logic [PW-1:0]     lead;
    logic              load_pos;

    function automatic logic [7:0] char_at(pos_e p, logic [PW-1:0] k, logic [BW-1:0] b);
        case (p)
            P_SIGN:  char_at = 8'h2D;
            P_TERM:  char_at = TERM_CHAR;
            default: char_at = 8'h30 + {4'h0, b[4*k +: 4]};
        endcase
    endfunction

    function automatic logic last_at(pos_e p, logic [PW-1:0] k);
        last_at = (p == P_TERM) || (p == P_DIGIT && k == '0 && !TERM_EN);
    endfunction

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    // Highest nonzero digit wins; an all-zero result leaves the pointer on digit 0.
    always_comb begin
        lead = '0;
        if (!SUPPRESS_ZEROS) begin
            lead = PW'(DIGITS - 1);
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (bcd_q[4*i +: 4] != 4'd0) lead = PW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        char_d   = char_q;
        valid_d  = valid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        load_pos = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start_update) begin
                    neg_d   = SIGNED && bus.value[DATA_W-1];
                    mag_d   = (SIGNED && bus.value[DATA_W-1]) ? (~bus.value + DATA_W'(1))
                                                              : bus.value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) state_d = S_PREP;
            end
            S_PREP: begin
                pos_d    = neg_q ? P_SIGN : P_DIGIT;
                ptr_d    = lead;
                load_pos = 1'b1;
                state_d  = S_EMIT;
            end
            S_EMIT: begin
                if (valid_q && bus.ready_i) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        // The sign keeps the pointer so the first digit follows it directly.
                        if (pos_q == P_SIGN)   pos_d = P_DIGIT;
                        else if (ptr_q == '0)  pos_d = P_TERM;
                        else                   ptr_d = ptr_q - 1'b1;
                        load_pos = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load_pos) begin
            char_d  = char_at(pos_d, ptr_d, bcd_q);
            last_d  = last_at(pos_d, ptr_d);
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            pos_q   <= P_DIGIT;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            char_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            char_q  <= char_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.char    = char_q;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
endmodule

// File: tb/tb_num2ascii_dec.sv
// Directed bench for num2ascii_dec: four configurations share one stimulus stream
// (A unsigned/suppress, B no suppression, C signed 8-bit, D terminator; '|' stands for 8'h0A).
module tb_num2ascii_dec;
    logic        CLK   = 1'b0;
    logic        RST   = 1'b0;
    logic        start = 1'b0;
    logic [31:0] value = '0;
    logic        ready = 1'b1;

    always #5 CLK = ~CLK;

    num2ascii_dec_if #(.DATA_W(32)) ifa ();
    num2ascii_dec_if #(.DATA_W(32)) ifb ();
    num2ascii_dec_if #(.DATA_W(8))  ifc ();
    num2ascii_dec_if #(.DATA_W(32)) ifd ();

    assign ifa.start_update = start;  assign ifa.value = value;       assign ifa.ready_i = ready;
    assign ifb.start_update = start;  assign ifb.value = value;       assign ifb.ready_i = ready;
    assign ifc.start_update = start;  assign ifc.value = value[7:0];  assign ifc.ready_i = ready;
    assign ifd.start_update = start;  assign ifd.value = value;       assign ifd.ready_i = ready;

    num2ascii_dec #(.DATA_W(32), .DIGITS(10), .SIGNED(1'b0), .SUPPRESS_ZEROS(1'b1), .TERM_EN(1'b0))
        u_a (.CLK(CLK), .RST(RST), .bus(ifa));
    num2ascii_dec #(.DATA_W(32), .DIGITS(10), .SIGNED(1'b0), .SUPPRESS_ZEROS(1'b0), .TERM_EN(1'b0))
        u_b (.CLK(CLK), .RST(RST), .bus(ifb));
    num2ascii_dec #(.DATA_W(8), .DIGITS(3), .SIGNED(1'b1), .SUPPRESS_ZEROS(1'b1), .TERM_EN(1'b0))
        u_c (.CLK(CLK), .RST(RST), .bus(ifc));
    num2ascii_dec #(.DATA_W(32), .DIGITS(10), .SIGNED(1'b0), .SUPPRESS_ZEROS(1'b1), .TERM_EN(1'b1),
                    .TERM_CHAR(8'h0A))
        u_d (.CLK(CLK), .RST(RST), .bus(ifd));

    logic [3:0]      vld, lst, bsy;
    logic [3:0][7:0] chr;
    assign vld = {ifd.valid_o, ifc.valid_o, ifb.valid_o, ifa.valid_o};
    assign lst = {ifd.last_o,  ifc.last_o,  ifb.last_o,  ifa.last_o};
    assign bsy = {ifd.busy,    ifc.busy,    ifb.busy,    ifa.busy};
    assign chr = {ifd.char,    ifc.char,    ifb.char,    ifa.char};

    typedef struct {
        logic [31:0] val;
        bit          rnd;
        string       e0, e1, e2, e3;
    } vec_t;

    vec_t tab[8];
    int   nvec;
    int   nmis;

    function automatic vec_t mk(logic [31:0] v, bit r, string a, string b, string c, string d);
        vec_t t;
        t.val = v; t.rnd = r; t.e0 = a; t.e1 = b; t.e2 = c; t.e3 = d;
        return t;
    endfunction

    task automatic chk_s(string name, string got, string exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endtask

    task automatic chk_i(string name, int got, int exp);
        nvec++;
        if (got != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (bsy != 4'b0 && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (bsy != 4'b0) chk_i({name, "/idle_timeout"}, int'(bsy), 0);
    endtask

    // Applies one conversion, records every handshaken character per instance and checks
    // output stability under backpressure. pulse=1 adds ignored starts in CONVERT and EMIT.
    task automatic run(int id, vec_t v, bit pulse);
        string      got[4], ex[4];
        int         nlast[4], lpos[4], unst[4];
        logic [7:0] pc[4];
        logic [3:0] pv, pl;
        logic       pr;
        int         cyc;
        bit         done, emit_pulsed;
        ex[0] = v.e0; ex[1] = v.e1; ex[2] = v.e2; ex[3] = v.e3;
        for (int i = 0; i < 4; i++) begin
            got[i] = ""; nlast[i] = 0; lpos[i] = -1; unst[i] = 0; pc[i] = 8'h00;
        end
        @(negedge CLK);
        start = 1'b1; value = v.val; ready = pulse ? 1'b0 : 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        pv = '0; pl = '0; pr = 1'b1;
        cyc = 0; done = 1'b0; emit_pulsed = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) begin
                if (pv[i] && !pr && (!vld[i] || chr[i] != pc[i] || lst[i] != pl[i])) unst[i]++;
                if (vld[i] && ready) begin
                    got[i] = (chr[i] == 8'h0A) ? $sformatf("%s|", got[i])
                                               : $sformatf("%s%c", got[i], chr[i]);
                    if (lst[i]) begin
                        nlast[i]++;
                        lpos[i] = got[i].len() - 1;
                    end
                end
                pv[i] = vld[i]; pc[i] = chr[i]; pl[i] = lst[i];
            end
            pr   = ready;
            done = (bsy == 4'b0);
            cyc++;
            @(posedge CLK); #1;
            if (pulse) begin
                start = 1'b0;
                if (cyc == 3) begin
                    start = 1'b1; value = 32'd12345;
                end else if (!emit_pulsed && vld[0]) begin
                    start = 1'b1; value = 32'd7; emit_pulsed = 1'b1;
                end else if (emit_pulsed) begin
                    ready = 1'b1;
                end
            end else if (v.rnd) begin
                ready = 1'($urandom_range(0, 1));
            end
        end
        ready = 1'b1;
        if (!done) chk_i($sformatf("vec%0d/timeout", id), int'(bsy), 0);
        for (int i = 0; i < 4; i++) begin
            chk_s($sformatf("vec%0d/inst%0d/string", id, i), got[i], ex[i]);
            chk_i($sformatf("vec%0d/inst%0d/last_count", id, i), nlast[i], 1);
            chk_i($sformatf("vec%0d/inst%0d/last_pos", id, i), lpos[i], ex[i].len() - 1);
            chk_i($sformatf("vec%0d/inst%0d/unstable", id, i), unst[i], 0);
        end
    endtask

    task automatic chk_reset_state(string name);
        chk_i({name, "/flags"}, int'({bsy, vld, lst}), 0);
        chk_i({name, "/char"}, int'(chr), 0);
    endtask

    // Latency of the basic 12345 case on instance A, counted in edges after the accept edge.
    task automatic timing();
        int first_v = -1, first_b = -1;
        @(negedge CLK);
        start = 1'b1; value = 32'd12345; ready = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        chk_i("timing/busy_after_accept", int'(bsy[0]), 1);
        for (int k = 1; k <= 80 && first_b < 0; k++) begin
            @(posedge CLK); #1;
            if (vld[0] && first_v < 0) first_v = k;
            if (!bsy[0] && first_b < 0) first_b = k;
        end
        chk_i("timing/first_valid", first_v, 33);
        chk_i("timing/busy_low", first_b, 38);
        wait_idle("timing");
    endtask

    task automatic rst_mid(bit in_emit);
        string nm = in_emit ? "rst_emit" : "rst_convert";
        int    n  = 0;
        @(negedge CLK);
        start = 1'b1; value = 32'd905; ready = in_emit ? 1'b0 : 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        if (!in_emit) begin
            repeat (10) @(posedge CLK);
        end else begin
            while (!vld[0] && n < 60) begin
                @(posedge CLK); #1;
                n++;
            end
            chk_i({nm, "/reached_emit"}, int'(vld[0]), 1);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk_reset_state(nm);
        @(negedge CLK);
        RST = 1'b1; ready = 1'b1;
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        tab[0] = mk(32'd12345,    1'b0, "12345",      "0000012345", "57",   "12345|");
        tab[1] = mk(32'd0,        1'b0, "0",          "0000000000", "0",    "0|");
        tab[2] = mk(32'hFFFFFFFF, 1'b1, "4294967295", "4294967295", "-1",   "4294967295|");
        tab[3] = mk(32'd7,        1'b0, "7",          "0000000007", "7",    "7|");
        tab[4] = mk(32'd905,      1'b1, "905",        "0000000905", "-119", "905|");
        tab[5] = mk(32'h80,       1'b0, "128",        "0000000128", "-128", "128|");
        tab[6] = mk(32'h7F,       1'b1, "127",        "0000000127", "127",  "127|");
        tab[7] = mk(32'hFF,       1'b0, "255",        "0000000255", "-1",   "255|");

        repeat (3) @(posedge CLK);
        #1;
        chk_reset_state("reset");
        @(negedge CLK);
        RST = 1'b1;

        timing();
        for (int k = 0; k < 8; k++) run(k, tab[k], 1'b0);
        run(100, tab[4], 1'b1);
        rst_mid(1'b0);
        run(101, tab[0], 1'b0);
        rst_mid(1'b1);
        run(102, tab[5], 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/num2ascii_dec.md
# num2ascii_dec

Parametrised binary-to-decimal ASCII serialiser: accepts an unsigned or two's-complement word, converts it to BCD with an iterative shift-add-3 (double-dabble) engine, then streams the digits as ASCII characters under a valid/ready handshake. It is the generalised successor of the fixed 32-bit, 10-digit counter-to-text converter. It sits between statistics counters (error rate, packet counts) and the UART/LCD text path. Over the fixed converter it adds:
- configurable width,
- leading-zero suppression,
- signed mode,
- an optional terminator character,
- output backpressure.

## Interface
- DATA_W, 32, input word width (2..64)
- DIGITS, 10, BCD digit count; must be ≥ ceil(DATA_W·log10 2), e.g. 10 for 32, 3 for 8
- SIGNED, 0, 1 = treat `value` as two's complement and emit '-' for negatives
- SUPPRESS_ZEROS, 1, 1 = omit leading zero digits (value 0 still emits "0")
- TERM_EN, 0, 1 = append TERM_CHAR after the last digit
- TERM_CHAR, 8'h0A, terminator character
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-low
- start_update  in  1  start request; sampled only when busy=0
- value  in  DATA_W  number to convert; captured on the accepted start
- busy  out  1  high from the cycle after start is accepted until the last character handshake completes
- char  out  8  ASCII character
- valid_o  out  1  char valid
- ready_i  in  1  downstream accepts char when valid_o & ready_i
- last_o  out  1  marks the final character of the string; qualified by valid_o

## Operation
States: IDLE → CONVERT → PREP → EMIT → IDLE.

- **IDLE:** busy=0, valid_o=0.
  - start_update=1 captures magnitude and sign, clears the BCD register, clears the shift counter, and moves to CONVERT.
  - Magnitude is `value`, or −`value` when SIGNED and value[DATA_W-1]=1. Negation is computed at DATA_W bits and interpreted unsigned, so the most-negative value gives magnitude 2^(DATA_W-1).
- **CONVERT:** exactly DATA_W cycles. Each cycle:
  - every BCD nibble ≥5 gets +3;
  - then {BCD, magnitude} shifts left by 1.
  - After DATA_W shifts, go to PREP.
- **PREP:** one cycle.
  - Priority-encode the first nonzero digit. With SUPPRESS_ZEROS=0, emission starts at digit DIGITS-1.
  - An all-zero result starts at digit 0.
  - Load the emit pointer and the pending-sign flag.
- **EMIT:** presents one character at a time, in this order:
  - '-' (if negative);
  - digits from most significant down to digit 0, each as 8'h30+nibble;
  - TERM_CHAR (if TERM_EN).
- **Handshake rules in EMIT:**
  - char, valid_o and last_o are held stable while valid_o & !ready_i.
  - On each handshake the next character appears in the following cycle, so throughput is 1 char/cycle when ready_i stays high.
  - After the handshake with last_o=1, the next cycle enters IDLE with valid_o=0 and busy=0.
- start_update while busy=1 is ignored; it is not queued.
- Changes on `value` after capture have no effect.
- **Reset:** RST=0 at any clock edge, including mid-CONVERT or mid-EMIT with a handshake pending, forces:
  - state=IDLE, busy=0, valid_o=0, last_o=0, char=8'h00;
  - the next cycle behaves as a fresh IDLE.
- All outputs are registered.

## Timing
- Reset values: char=8'h00, valid_o=0, last_o=0, busy=0.
- Start accepted at clock edge t.
  - busy=1 from cycle t+1.
  - CONVERT occupies cycles t+1 … t+DATA_W.
  - PREP occupies cycle t+DATA_W+1.
  - The first char has valid_o=1 at cycle t+DATA_W+2.
- With ready_i held high, a string of N characters completes its last handshake at t+DATA_W+N+1.
  - busy=0 at t+DATA_W+N+2.
  - A new start may be sampled at that cycle.
- Character count N = sign(0/1) + emitted digits + TERM_EN.
  - Emitted digits = DIGITS if SUPPRESS_ZEROS=0.
  - Otherwise emitted digits = max(1, significant digits).
- last_o is asserted together with valid_o on exactly one character per conversion.

## Test plan
- **Basic conversion:** DATA_W=32, SUPPRESS_ZEROS=1, ready_i=1, value=12345 → "1","2","3","4","5".
  - valid_o first high 34 cycles after start.
  - last_o on "5".
  - busy low 39 cycles after start.
- **Zero and full scale:** value=0 → single "0" with last_o. value=32'hFFFFFFFF → "4294967295". With SUPPRESS_ZEROS=0, value=7 → "0000000007".
- **Signed mode:** SIGNED=1, DATA_W=8, DIGITS=3.
  - 8'h80 → "-","1","2","8".
  - 8'hFF → "-","1".
  - 8'h7F → "1","2","7".
- **Backpressure and terminator:** TERM_EN=1, value=905, ready_i toggled pseudo-randomly → "9","0","5",8'h0A.
  - char is stable whenever valid_o & !ready_i.
  - last_o appears only on 8'h0A.
- **Start while busy:** pulse start_update with a new value during CONVERT and again during EMIT.
  - Both pulses are ignored.
  - Output string is from the original value only.
- **Reset mid-operation:** assert RST=0 mid-CONVERT, and separately mid-EMIT with ready_i=0.
  - All outputs return to reset values the next cycle.
  - The following start converts correctly.
